fir_coe_loader: RTL and testbench
=================================

FIR_COE_LOADER -- requirements
Module: fir_coe_loader

Interface
REQ-001 SHALL have parameter: NTAPS, default 11, number of coefficient slots sequenced; legal range 2..11.
REQ-002 SHALL have parameter: IDLE_CODE, default 4'd15, count_coe value driven when not sequencing; must be greater than NTAPS.
REQ-003 SHALL have port: clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: wr_en  input  1  host shadow-buffer write strobe.
REQ-006 SHALL have port: wr_addr  input  4  shadow slot index.
REQ-007 SHALL have port: wr_data  input  4  coefficient value.
REQ-008 SHALL have port: start  input  1  request to sequence the shadow buffer into the filter.
REQ-009 SHALL have port: abort  input  1  cancel an in-progress sequence without a commit.
REQ-010 SHALL have port: count_coe  output  4  slot index, or commit code NTAPS, to the filter.
REQ-011 SHALL have port: coe  output  4  coefficient value to the filter.
REQ-012 SHALL have port: busy  output  1  high while sequencing.
REQ-013 SHALL have port: done  output  1  one-cycle pulse after a successful commit.
REQ-014 SHALL have port: wr_err  output  1  one-cycle pulse for a rejected write.
REQ-015 SHALL have port: rd_addr  input  4  readback slot index.
REQ-016 SHALL have port: rd_data  output  4  readback value.

Function
REQ-017 SHALL hold a shadow buffer of NTAPS x 4-bit registers.
REQ-018 SHALL write wr_data into slot wr_addr when wr_en is high, the block is in IDLE and wr_addr < NTAPS.
REQ-019 SHALL ignore a write with wr_addr >= NTAPS or a write outside IDLE, and SHALL pulse wr_err in the following cycle.
REQ-020 SHALL use the state machine IDLE -> LOAD -> COMMIT -> IDLE; all outputs SHALL be registered.
REQ-021 IDLE: count_coe=IDLE_CODE, coe=0, busy=0; start=1 SHALL move the block to LOAD with slot index 0.
REQ-022 LOAD: SHALL drive count_coe=i and coe=shadow[i] for i=0..NTAPS-1, one slot per cycle, with busy=1.
REQ-023 COMMIT: SHALL drive count_coe=NTAPS and coe=0 for exactly one cycle with busy=1, then return to IDLE.
REQ-024 SHALL pulse done in the first IDLE cycle after COMMIT.
REQ-025 Timing, with start sampled at cycle N: count_coe=0 at N+1; count_coe=NTAPS-1 at N+NTAPS; commit at N+NTAPS+1; done=1, busy=0 and count_coe=IDLE_CODE at N+NTAPS+2.
REQ-026 SHALL sequence a value written in the same cycle as start, because the write is accepted before LOAD begins.
REQ-027 SHALL ignore start while busy, with no restart and no error.
REQ-028 abort in LOAD or COMMIT SHALL return the block to IDLE the next cycle with count_coe=IDLE_CODE and no commit code driven; done SHALL NOT pulse.
REQ-029 abort and start together in IDLE: abort SHALL win and the block SHALL stay IDLE.
REQ-030 SHALL ignore abort in IDLE.
REQ-031 SHALL leave the shadow buffer unchanged by sequencing and by abort.

Reset
REQ-032 While rst=0 at a clock edge, SHALL go to IDLE with count_coe=IDLE_CODE, coe=0, busy=0, done=0, wr_err=0 and rd_data=0.
REQ-033 Reset SHALL load the shadow buffer with slot 4..6 = 7 and all other slots = 0, matching the filter's reset coefficients.
REQ-034 Reset during LOAD or COMMIT SHALL follow REQ-032 and SHALL NOT emit a commit code.

Configuration
REQ-035 With macro FIR_COE_READBACK_EN defined, rd_data SHALL equal shadow[rd_addr] one cycle after rd_addr is presented; rd_addr >= NTAPS SHALL return 0.
REQ-036 Without FIR_COE_READBACK_EN, rd_data SHALL be constant 0, rd_addr SHALL be ignored, and the ports SHALL remain present.

Verification
REQ-037 Reset release, then start at cycle N -> count_coe 0..10 with coe 0,0,0,0,7,7,7,0,0,0,0; count_coe=11 at N+12; done at N+13.
REQ-038 Write slots 0..10 with values 1..11, then start -> coe sequence 1..11 in order; busy high for exactly 12 cycles.
REQ-039 Write to addr 11, and a write during LOAD -> wr_err pulses once for each; shadow unchanged, confirmed by readback with FIR_COE_READBACK_EN.
REQ-040 abort at count_coe=5 -> next cycle count_coe=15, busy=0; no count_coe=11 and no done.
REQ-041 rst=0 at count_coe=7 -> next cycle count_coe=15; the shadow holds the default pattern after reset.
REQ-042 start and wr_en (addr 0, data 9) in the same IDLE cycle -> first LOAD cycle drives coe=9; start while busy -> no change to the sequence.

Source files
------------

// File: rtl/fir_coe_loader.sv
// fir_coe_loader: sequences a host-written shadow coefficient buffer into a FIR filter, then commits it.
// Optional shadow readback on rd_addr/rd_data is enabled by defining FIR_COE_READBACK_EN.
module fir_coe_loader #(
    parameter int         NTAPS     = 11,
    parameter logic [3:0] IDLE_CODE = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] count_coe,
    output logic [3:0] coe,
    output logic       busy,
    output logic       done,
    output logic       wr_err,
    input  logic [3:0] rd_addr,
    output logic [3:0] rd_data
);
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
    localparam logic [3:0] L_N    = 4'(NTAPS);
    localparam logic [3:0] L_LAST = 4'(NTAPS - 1);
    state_t     r_state;
    logic [3:0] r_shadow [NTAPS];
    logic [3:0] r_idx, r_count_coe, r_coe, r_rd_data;
    logic       r_busy, r_done, r_wr_err;
    logic       w_wr_ok;
    logic [3:0] w_first_coe, w_next_coe;
`ifdef FIR_COE_READBACK_EN
    logic [3:0] w_rd_val;
`else
    logic       w_unused_rd;
    assign w_unused_rd = ^rd_addr;
`endif
    assign w_wr_ok = wr_en && r_state == IDLE && wr_addr < L_N;
    // a slot-0 write landing with start must reach the filter in the first LOAD cycle
    assign w_first_coe = (w_wr_ok && wr_addr == 4'd0) ? wr_data : r_shadow[0];
    always_comb begin
        w_next_coe = '0;
`ifdef FIR_COE_READBACK_EN
        w_rd_val = '0;
`endif
        for (int i = 0; i < NTAPS; i++) begin
            if (r_idx + 4'd1 == 4'(i)) w_next_coe = r_shadow[i];
`ifdef FIR_COE_READBACK_EN
            if (rd_addr == 4'(i)) w_rd_val = r_shadow[i];
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_count_coe <= IDLE_CODE;
            r_coe       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_err    <= 1'b0;
            r_rd_data   <= '0;
            for (int i = 0; i < NTAPS; i++) r_shadow[i] <= (i >= 4 && i <= 6) ? 4'd7 : 4'd0;
        end else begin
            r_done   <= 1'b0;
            r_wr_err <= wr_en && !w_wr_ok;
`ifdef FIR_COE_READBACK_EN
            r_rd_data <= w_rd_val;
`else
            r_rd_data <= '0;
`endif
            for (int i = 0; i < NTAPS; i++)
                if (w_wr_ok && wr_addr == 4'(i)) r_shadow[i] <= wr_data;
            if (abort) begin
                r_state     <= IDLE;
                r_count_coe <= IDLE_CODE;
                r_coe       <= '0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (start) begin
                        r_state     <= LOAD;
                        r_idx       <= '0;
                        r_count_coe <= '0;
                        r_coe       <= w_first_coe;
                        r_busy      <= 1'b1;
                    end
                    LOAD: if (r_idx == L_LAST) begin
                        r_state     <= COMMIT;
                        r_count_coe <= L_N;
                        r_coe       <= '0;
                    end else begin
                        r_idx       <= r_idx + 4'd1;
                        r_count_coe <= r_idx + 4'd1;
                        r_coe       <= w_next_coe;
                    end
                    COMMIT: begin
                        r_state     <= IDLE;
                        r_count_coe <= IDLE_CODE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign count_coe = r_count_coe;
    assign coe       = r_coe;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_err    = r_wr_err;
    assign rd_data   = r_rd_data;
endmodule

// File: tb/tb_fir_coe_loader.sv
// tb_fir_coe_loader: randomized scenario bench for fir_coe_loader against a slot-array model.
// Readback expectations follow FIR_COE_READBACK_EN when it is defined for the build.
module tb_fir_coe_loader;
    localparam int         NTAPS     = 11;
    localparam logic [3:0] IDLE_CODE = 4'd15;
    logic       clk = 0, rst = 0, wr_en = 0, start = 0, abort = 0;
    logic [3:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
    logic [3:0] count_coe, coe, rd_data;
    logic       busy, done, wr_err;
    int         checks = 0, errors = 0;
    logic [3:0] m [NTAPS];

    fir_coe_loader #(.NTAPS(NTAPS), .IDLE_CODE(IDLE_CODE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .abort(abort), .count_coe(count_coe), .coe(coe), .busy(busy),
        .done(done), .wr_err(wr_err), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) m[i] = (i >= 4 && i <= 6) ? 4'd7 : 4'd0;
    endtask

    task automatic test_reset();
        rst = 0;
        step();
        step();
        checks++;
        if ({count_coe, coe, busy, done, wr_err, rd_data} !== {IDLE_CODE, 4'd0, 3'b000, 4'd0}) begin
            errors++;
            $display("FAIL reset: got count_coe=%0d coe=%0d busy=%b done=%b wr_err=%b rd_data=%0d, want 15 0 0 0 0 0",
                     count_coe, coe, busy, done, wr_err, rd_data);
        end
        rst = 1;
        model_reset();
        step();
        checks++;
        if ({count_coe, busy, done} !== {IDLE_CODE, 2'b00}) begin
            errors++;
            $display("FAIL reset_release: got count_coe=%0d busy=%b done=%b, want 15 0 0", count_coe, busy, done);
        end
    endtask

    // kind 0: run to completion, 1: abort after cycle stop_k, 2: reset after cycle stop_k
    task automatic test_sequence(input string name, input int stop_k, input int kind,
                                 input bit sw, input logic [3:0] sd);
        int busy_cycles = 0;
        start = 1;
        if (sw) begin
            wr_en = 1; wr_addr = 0; wr_data = sd; m[0] = sd;
        end
        step();
        start = 0;
        wr_en = 0;
        for (int k = 1; k <= NTAPS + 3; k++) begin
            logic [3:0] ec, ee;
            logic       eb, ed;
            if (stop_k > 0 && k > stop_k) begin
                ec = IDLE_CODE; ee = 0; eb = 0; ed = 0;
            end else if (k <= NTAPS) begin
                ec = 4'(k - 1); ee = m[k-1]; eb = 1; ed = 0;
            end else if (k == NTAPS + 1) begin
                ec = 4'(NTAPS); ee = 0; eb = 1; ed = 0;
            end else begin
                ec = IDLE_CODE; ee = 0; eb = 0; ed = (k == NTAPS + 2);
            end
            busy_cycles += int'(busy);
            checks++;
            if ({count_coe, coe, busy, done} !== {ec, ee, eb, ed}) begin
                errors++;
                $display("FAIL seq_%s k=%0d: got count_coe=%0d coe=%0d busy=%b done=%b, want %0d %0d %b %b",
                         name, k, count_coe, coe, busy, done, ec, ee, eb, ed);
            end
            abort = 0;
            rst = 1;
            start = 0;
            if (k == stop_k) begin
                if (kind == 1) abort = 1;
                else rst = 0;
            end else if ((stop_k == 0 || k < stop_k) && k <= NTAPS) begin
                start = 1'($urandom % 2);
            end
            step();
        end
        abort = 0;
        rst = 1;
        start = 0;
        if (kind == 2) model_reset();
        if (stop_k == 0) begin
            checks++;
            if (busy_cycles != NTAPS + 1) begin
                errors++;
                $display("FAIL busy_len_%s: got %0d cycles, want %0d", name, busy_cycles, NTAPS + 1);
            end
        end
    endtask

    task automatic test_readback();
        for (int a = 0; a < 16; a++) begin
            logic [3:0] exp;
            rd_addr = 4'(a);
            step();
`ifdef FIR_COE_READBACK_EN
            exp = (a < NTAPS) ? m[a] : 4'd0;
`else
            exp = 4'd0;
`endif
            checks++;
            if (rd_data !== exp) begin
                errors++;
                $display("FAIL readback addr=%0d: got %0d, want %0d", a, rd_data, exp);
            end
        end
        rd_addr = 0;
    endtask

    task automatic test_write_ramp();
        for (int a = 0; a < NTAPS; a++) begin
            wr_en = 1; wr_addr = 4'(a); wr_data = 4'(a + 1); m[a] = 4'(a + 1);
            step();
            wr_en = 0;
            checks++;
            if (wr_err !== 1'b0) begin
                errors++;
                $display("FAIL ramp_wr_err addr=%0d: got %b, want 0", a, wr_err);
            end
        end
    endtask

    task automatic test_random_writes();
        for (int n = 0; n < 24; n++) begin
            int         a = $urandom_range(0, 15);
            logic [3:0] d = 4'($urandom);
            wr_en = 1; wr_addr = 4'(a); wr_data = d;
            if (a < NTAPS) m[a] = d;
            step();
            wr_en = 0;
            checks++;
            if (wr_err !== (a >= NTAPS)) begin
                errors++;
                $display("FAIL rand_wr_err addr=%0d: got %b, want %b", a, wr_err, a >= NTAPS);
            end
        end
        step();
    endtask

    task automatic test_wr_err();
        wr_en = 1; wr_addr = 4'd11; wr_data = 4'd5;
        step();
        wr_en = 0;
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_addr11: got %b, want 1", wr_err);
        end
        step();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_addr11_once: got %b, want 0", wr_err);
        end
    endtask

    task automatic test_wr_err_load();
        start = 1;
        step();
        start = 0;
        wr_en = 1; wr_addr = 4'd3; wr_data = ~m[3];
        step();
        wr_en = 0;
        checks++;
        if (wr_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_load: got wr_err=%b busy=%b, want 1 1", wr_err, busy);
        end
        step();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_load_once: got %b, want 0", wr_err);
        end
        for (int i = 0; i < NTAPS; i++) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_load_end: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_idle_abort();
        logic [3:0] d = 4'($urandom);
        abort = 1; start = 1; wr_en = 1; wr_addr = 4'd2; wr_data = d; m[2] = d;
        step();
        abort = 0; start = 0; wr_en = 0;
        checks++;
        if ({count_coe, busy, wr_err} !== {IDLE_CODE, 2'b00}) begin
            errors++;
            $display("FAIL idle_abort: got count_coe=%0d busy=%b wr_err=%b, want 15 0 0", count_coe, busy, wr_err);
        end
        step();
        checks++;
        if ({count_coe, busy, done} !== {IDLE_CODE, 2'b00}) begin
            errors++;
            $display("FAIL idle_abort_hold: got count_coe=%0d busy=%b done=%b, want 15 0 0", count_coe, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_sequence("default", 0, 0, 0, 4'd0);
        test_readback();
        test_write_ramp();
        test_sequence("ramp", 0, 0, 0, 4'd0);
        test_wr_err();
        test_wr_err_load();
        test_readback();
        test_sequence("abort5", 6, 1, 0, 4'd0);
        test_readback();
        test_sequence("rst7", 8, 2, 0, 4'd0);
        test_readback();
        test_sequence("after_rst", 0, 0, 0, 4'd0);
        test_idle_abort();
        test_random_writes();
        test_sequence("random", 0, 0, 0, 4'd0);
        test_sequence("same_cycle", 0, 0, 1, 4'd9);
        test_readback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
